// File: rtl/logit_aprox_seq.sv
// Inverse of the shift-based Q8.8 sigmoid: x = logit(y), normalised one shift per clock.
// Latency: accept to out_valid is n+1 cycles for in-range y and 1 cycle for saturating y.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module logit_aprox_seq #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sat
);
    localparam int INT_W = DATA_W - FRAC_W;
    localparam int N_W   = $clog2(FRAC_W);

    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] HALF    = DATA_W'(1) << (FRAC_W - 1);
    localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [FRAC_W:0]   R_ONE   = (FRAC_W+1)'(1) << FRAC_W;
    localparam logic [FRAC_W:0]   R_HALF  = (FRAC_W+1)'(1) << (FRAC_W - 1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t            state;
    logic [FRAC_W:0]   r;
    logic [N_W-1:0]    n;
    logic              sign;
    logic              sat_pend;

    logic              in_sign;
    logic [FRAC_W-1:0] q;
    logic [FRAC_W:0]   r_diff;
    logic [FRAC_W-1:0] f;
    logic [DATA_W-1:0] mag;

    // Fold the upper half onto the lower so normalisation only ever sees q in 1..half.
    assign in_sign = (in_data >= HALF);
    assign q       = in_sign ? FRAC_W'(ONE - in_data) : in_data[FRAC_W-1:0];
    assign r_diff  = R_ONE - r;
    assign f       = FRAC_W'({r_diff, 1'b0});
    assign mag     = {INT_W'(n), f};

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r         <= '0;
            n         <= '0;
            sign      <= 1'b0;
            sat_pend  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= NORM;
                        if (in_data[DATA_W-1] || in_data == '0) begin
                            out_data <= SAT_NEG;
                            out_sat  <= 1'b1;
                            sat_pend <= 1'b1;
                        end else if (in_data >= ONE) begin
                            out_data <= SAT_POS;
                            out_sat  <= 1'b1;
                            sat_pend <= 1'b1;
                        end else begin
                            sign <= in_sign;
                            r    <= {q, 1'b0};
                            n    <= '0;
                        end
                    end
                end
                NORM: begin
                    // Saturated results spend one cycle here so every result has latency >= 1.
                    if (sat_pend) begin
                        sat_pend  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (r <= R_HALF) begin
                        r <= r << 1;
                        n <= n + 1'b1;
                    end else begin
                        out_data  <= sign ? mag : -mag;
                        out_sat   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logit_aprox_seq.sv
// Bench for logit_aprox_seq: the reference inverts the forward sigmoid by exhaustive search
// over Q8.8 magnitudes, a negedge monitor checks every valid output cycle against it.
module tb_logit_aprox_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sat;

    logit_aprox_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = 0;
    int prev_acc = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [15:0] y;
        logic [15:0] x;
        logic        sat;
        int          lat;
        int          acc;
    } exp_t;
    exp_t expq[$];
    bit   seen_first = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Forward sigmoid for x = n + k/256: y = 1 - (2 - k/256)/2^(n+2); negative x mirrors it.
    // Scaled by 256*2^(n+2) everything is integer, so the exact inverse is found by search.
    function automatic void model(input logic [15:0] y, output logic [15:0] x,
                                  output logic sat, output int lat);
        x   = 16'hDEAD;
        sat = 1'b0;
        lat = -1;
        if (y[15] || y == 16'h0000) begin
            x = 16'h8000; sat = 1'b1; lat = 1;
        end else if (y >= 16'h0100) begin
            x = 16'h7FFF; sat = 1'b1; lat = 1;
        end else begin
            for (int m = 0; m < 2048; m++) begin
                int n = m >> 8;
                int k = m & 255;
                int s = 1 << (n + 2);
                if (int'(y) * s == 256 * s - (512 - k)) begin x = 16'(m);  lat = n + 1; end
                if (int'(y) * s == 512 - k)             begin x = 16'(-m); lat = n + 1; end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            seen_first = 1'b0;
        end else begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk($sformatf("x(y=%h)", expq[0].y), out_data, expq[0].x);
                    chk($sformatf("sat(y=%h)", expq[0].y), out_sat, expq[0].sat);
                    chk("in_ready_busy", in_ready, 0);
                    if (!seen_first) begin
                        chk($sformatf("lat(y=%h)", expq[0].y), cyc - expq[0].acc, expq[0].lat);
                        seen_first = 1'b1;
                    end
                    if (out_ready) begin
                        void'(expq.pop_front());
                        seen_first = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                model(in_data, e.x, e.sat, e.lat);
                e.y = in_data;
                e.acc = cyc + 1;
                expq.push_back(e);
                prev_acc = last_acc;
                last_acc = cyc + 1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom % 4) != 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called just after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [15:0] y);
        int g = 0;
        in_data  = y;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 60) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic run_one(input logic [15:0] y, input logic [15:0] xe,
                           input logic se, input int late);
        int t0, g;
        send(y);
        t0 = cyc;
        g = 0;
        @(negedge clk);
        while (!out_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("dir_x(y=%h)", y), out_data, xe);
        chk($sformatf("dir_sat(y=%h)", y), out_sat, se);
        chk($sformatf("dir_lat(y=%h)", y), cyc - t0, late);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while ((expq.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            g++;
        end
        if (g >= 200) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] mx;
        logic        ms;
        int          ml;
        logic [15:0] y;

        // Hand-derived values pin the reference before it is trusted.
        model(16'h0080, mx, ms, ml); chk("model_0080", mx, 16'h0000); chk("model_0080_lat", ml, 1);
        model(16'h00A0, mx, ms, ml); chk("model_00A0", mx, 16'h0080);
        model(16'h0040, mx, ms, ml); chk("model_0040", mx, 16'hFF00); chk("model_0040_lat", ml, 2);
        model(16'h0001, mx, ms, ml); chk("model_0001", mx, 16'hF900); chk("model_0001_lat", ml, 8);
        model(16'h00FF, mx, ms, ml); chk("model_00FF", mx, 16'h0700);
        model(16'h0060, mx, ms, ml); chk("model_0060", mx, 16'hFF80);

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one(16'h0080, 16'h0000, 1'b0, 1);
        run_one(16'h00A0, 16'h0080, 1'b0, 1);
        run_one(16'h00C0, 16'h0100, 1'b0, 2);
        run_one(16'h0040, 16'hFF00, 1'b0, 2);
        run_one(16'h0001, 16'hF900, 1'b0, 8);
        run_one(16'h00FF, 16'h0700, 1'b0, 8);
        run_one(16'h0000, 16'h8000, 1'b1, 1);
        run_one(16'h0100, 16'h7FFF, 1'b1, 1);
        run_one(16'h0180, 16'h7FFF, 1'b1, 1);
        run_one(16'hFF00, 16'h8000, 1'b1, 1);

        // Backpressure with foreign data offered while the block is busy.
        out_ready = 1'b0;
        send(16'h0001);
        in_valid = 1'b1;
        in_data  = 16'h00C0;
        begin
            int g = 0;
            @(negedge clk);
            while (!out_valid && g < 40) begin
                @(negedge clk);
                g++;
            end
        end
        in_valid = 1'b0;
        repeat (5) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 16'hF900);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        drain();

        // Reset in the middle of normalisation abandons the result.
        send(16'h0001);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_sat", out_sat, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_one(16'h00C0, 16'h0100, 1'b0, 2);

        // Held in_valid: one result per latency + 2 cycles.
        in_data = 16'h00C0;
        in_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("tput_norm", last_acc - prev_acc, 4);
        in_data = 16'h0000;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
        chk("tput_sat", last_acc - prev_acc, 3);

        // Randomised traffic with random output stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            case ($urandom % 8)
                0:       y = 16'($urandom);
                1:       y = 16'($urandom_range(0, 16'h01FF));
                default: y = 16'($urandom_range(1, 255));
            endcase
            send(y);
            repeat ($urandom % 3) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        #1 out_ready = 1'b1;
        drain();

        // Every in-range y, checked exactly against the reference.
        for (int v = 1; v < 256; v++) send(16'(v));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
